// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: datapath widths, ALU encodings, ID/EX bundle.
// Consumed by id_ex_stage and fwd_mux.
package riscv_pkg;

    localparam int WIDTH = 32;
    localparam int RA_W  = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_SLL = 4'b1000
    } alu_op_e;

    typedef struct packed {
        logic             valid;
        logic [RA_W-1:0]  rs1;
        logic [RA_W-1:0]  rs2;
        logic [RA_W-1:0]  rd;
        logic [WIDTH-1:0] rs1_data;
        logic [WIDTH-1:0] rs2_data;
        logic [WIDTH-1:0] imm;
        alu_op_e          alu_ctrl;
        logic             alusrc;
        logic             reg_write;
        logic             mem_read;
    } id_ex_t;

    function automatic logic addr_hit(
        input logic [RA_W-1:0] a,
        input logic [RA_W-1:0] b
    );
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select: EX/MEM over MEM/WB over register-file data.
// Bypass is built only when ID_EX_FORWARD_EN is defined.
module fwd_mux
    import riscv_pkg::*;
(
    input  logic [RA_W-1:0]  rs_i,
    input  logic [WIDTH-1:0] reg_data_i,
    input  logic [RA_W-1:0]  mem_rd_i,
    input  logic             mem_reg_write_i,
    input  logic [WIDTH-1:0] mem_result_i,
    input  logic [RA_W-1:0]  wb_rd_i,
    input  logic             wb_reg_write_i,
    input  logic [WIDTH-1:0] wb_result_i,
    output logic [WIDTH-1:0] operand_o
);

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        operand_o = reg_data_i;
        if (mem_reg_write_i && addr_hit(mem_rd_i, rs_i)) begin
            operand_o = mem_result_i;
        end else if (wb_reg_write_i && addr_hit(wb_rd_i, rs_i)) begin
            operand_o = wb_result_i;
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{rs_i, mem_rd_i, mem_reg_write_i,
                             mem_result_i, wb_rd_i,
                             wb_reg_write_i, wb_result_i};
    assign operand_o = reg_data_i;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, load-use detect and ALU operand forwarding.
// ID_EX_FORWARD_EN enables the EX/MEM and MEM/WB bypass network.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             id_alusrc,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_reg_write,
    input  logic [WIDTH-1:0] mem_result,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             wb_reg_write,
    input  logic [WIDTH-1:0] wb_result,
    output logic             ex_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       ex_alu_ctrl,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RA_W-1:0]  ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             load_use
);

    id_ex_t           ex_q;
    id_ex_t           ex_d;
    id_ex_t           id_pkt;
    logic             hz_src;
    logic             rs_hit;
    logic [WIDTH-1:0] fwd_rs1;
    logic [WIDTH-1:0] fwd_rs2;

    // Without bypass, any in-flight writer must stall a dependent reader.
`ifdef ID_EX_FORWARD_EN
    assign hz_src = ex_q.mem_read;
`else
    assign hz_src = ex_q.reg_write;
`endif

    assign rs_hit = (id_rs1 == ex_q.rd) || (id_rs2 == ex_q.rd);

    assign load_use = ex_q.valid && hz_src && (ex_q.rd != '0)
                   && id_valid && rs_hit;

    always_comb begin
        id_pkt           = '0;
        id_pkt.valid     = id_valid;
        id_pkt.rs1       = id_rs1;
        id_pkt.rs2       = id_rs2;
        id_pkt.rd        = id_rd;
        id_pkt.rs1_data  = id_rs1_data;
        id_pkt.rs2_data  = id_rs2_data;
        id_pkt.imm       = id_imm;
        id_pkt.alu_ctrl  = alu_op_e'(id_alu_ctrl);
        id_pkt.alusrc    = id_alusrc;
        id_pkt.reg_write = id_reg_write;
        id_pkt.mem_read  = id_mem_read;
    end

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            if (load_use) begin
                ex_d = '0;
            end else begin
                ex_d = id_pkt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs_i            (ex_q.rs1),
        .reg_data_i      (ex_q.rs1_data),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .mem_result_i    (mem_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .operand_o       (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs_i            (ex_q.rs2),
        .reg_data_i      (ex_q.rs2_data),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .mem_result_i    (mem_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .operand_o       (fwd_rs2)
    );

    assign alu_a         = fwd_rs1;
    assign alu_b         = ex_q.alusrc ? ex_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_alu_ctrl   = ex_q.alu_ctrl;
    assign ex_rd         = ex_q.rd;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read   = ex_q.valid & ex_q.mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, stall/flush/reset
// sequences and randomized traffic against a reference model.
module tb_id_ex_stage;
    import riscv_pkg::*;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic             valid;
        logic [RA_W-1:0]  rs1;
        logic [RA_W-1:0]  rs2;
        logic [RA_W-1:0]  rd;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        logic [WIDTH-1:0] imm;
        logic [3:0]       ctrl;
        logic             src;
        logic             rw;
        logic             mr;
        logic             stall;
        logic             flush;
        logic [RA_W-1:0]  mrd;
        logic             mrw;
        logic [WIDTH-1:0] mres;
        logic [RA_W-1:0]  wrd;
        logic             wrw;
        logic [WIDTH-1:0] wres;
    } vin_t;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sd;
        logic [3:0]       ctrl;
        logic [RA_W-1:0]  rd;
        logic             rw;
        logic             mr;
    } out_t;

    typedef struct {
        vin_t in;
        logic lu_pre;
        out_t exp;
    } vec_t;

    // What the EX stage is believed to hold.
    typedef struct packed {
        logic             v;
        logic [RA_W-1:0]  rs1;
        logic [RA_W-1:0]  rs2;
        logic [RA_W-1:0]  rd;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        logic [WIDTH-1:0] imm;
        logic [3:0]       ctrl;
        logic             src;
        logic             rw;
        logic             mr;
    } mst_t;

    logic             clk = 1'b0;
    logic             reset;
    vin_t             cur;
    mst_t             m;
    out_t             got;
    logic             ex_valid;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       ex_alu_ctrl;
    logic [WIDTH-1:0] ex_store_data;
    logic [RA_W-1:0]  ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             load_use;
    int               n_vec = 0;
    int               n_bad = 0;
    vec_t             tbl [10];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (cur.stall),
        .flush         (cur.flush),
        .id_valid      (cur.valid),
        .id_rs1        (cur.rs1),
        .id_rs2        (cur.rs2),
        .id_rd         (cur.rd),
        .id_rs1_data   (cur.d1),
        .id_rs2_data   (cur.d2),
        .id_imm        (cur.imm),
        .id_alu_ctrl   (cur.ctrl),
        .id_alusrc     (cur.src),
        .id_reg_write  (cur.rw),
        .id_mem_read   (cur.mr),
        .mem_rd        (cur.mrd),
        .mem_reg_write (cur.mrw),
        .mem_result    (cur.mres),
        .wb_rd         (cur.wrd),
        .wb_reg_write  (cur.wrw),
        .wb_result     (cur.wres),
        .ex_valid      (ex_valid),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .ex_alu_ctrl   (ex_alu_ctrl),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .load_use      (load_use)
    );

    assign got = {ex_valid, alu_a, alu_b, ex_store_data,
                  ex_alu_ctrl, ex_rd, ex_reg_write, ex_mem_read};

    function automatic vin_t mk_in(
        input logic v, input int rs1, input int rs2, input int rd,
        input logic [31:0] d1, input logic [31:0] d2,
        input logic [31:0] imm, input int ctrl,
        input logic src, input logic rw, input logic mr,
        input int mrd, input logic mrw, input logic [31:0] mres,
        input int wrd, input logic wrw, input logic [31:0] wres
    );
        vin_t r;
        r = '0;
        r.valid = v;
        r.rs1 = RA_W'(rs1);
        r.rs2 = RA_W'(rs2);
        r.rd = RA_W'(rd);
        r.d1 = d1;
        r.d2 = d2;
        r.imm = imm;
        r.ctrl = 4'(ctrl);
        r.src = src;
        r.rw = rw;
        r.mr = mr;
        r.mrd = RA_W'(mrd);
        r.mrw = mrw;
        r.mres = mres;
        r.wrd = RA_W'(wrd);
        r.wrw = wrw;
        r.wres = wres;
        return r;
    endfunction

    function automatic out_t mk_out(
        input logic v, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] sd, input int ctrl, input int rd,
        input logic rw, input logic mr
    );
        return {v, a, b, sd, 4'(ctrl), RA_W'(rd), rw, mr};
    endfunction

    // Reference: newest bypass source wins, x0 never bypassed.
    function automatic logic [WIDTH-1:0] m_fwd(
        input logic [RA_W-1:0] rs, input logic [WIDTH-1:0] rf
    );
        if (FWD && cur.mrw && cur.mrd != 0 && cur.mrd == rs)
            return cur.mres;
        if (FWD && cur.wrw && cur.wrd != 0 && cur.wrd == rs)
            return cur.wres;
        return rf;
    endfunction

    function automatic out_t m_out();
        logic [WIDTH-1:0] f1 = m_fwd(m.rs1, m.d1);
        logic [WIDTH-1:0] f2 = m_fwd(m.rs2, m.d2);
        return {m.v, f1, (m.src ? m.imm : f2), f2,
                m.ctrl, m.rd, m.v & m.rw, m.v & m.mr};
    endfunction

    function automatic logic m_lu();
        logic hazard_kind = FWD ? m.mr : m.rw;
        return m.v && hazard_kind && m.rd != 0 && cur.valid
            && (cur.rs1 == m.rd || cur.rs2 == m.rd);
    endfunction

    task automatic m_step();
        if (cur.flush) m = '0;
        else if (cur.stall) m = m;
        else if (m_lu()) m = '0;
        else m = {cur.valid, cur.rs1, cur.rs2, cur.rd, cur.d1,
                  cur.d2, cur.imm, cur.ctrl, cur.src, cur.rw, cur.mr};
    endtask

    task automatic chk_out(input string name, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", name, got, exp);
        end
    endtask

    task automatic chk_lu(input string name, input logic exp);
        n_vec++;
        if (load_use !== exp) begin
            n_bad++;
            $display("FAIL %s: load_use got %b exp %b",
                     name, load_use, exp);
        end
    endtask

    initial begin
        cur = '0;
        m = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset_out", '0);
        chk_lu("reset_lu", 1'b0);
        reset = 1'b0;

        tbl[0] = '{mk_in(1,3,4,6,5,7,0,ALU_ADD,0,1,0, 0,0,0, 0,0,0),
                   1'b0, mk_out(1,5,7,7,ALU_ADD,6,1,0)};
        tbl[1] = '{mk_in(1,3,4,6,5,7,0,ALU_ADD,0,1,0,
                         3,1,'hAA, 3,1,'hBB),
                   1'b0, mk_out(1,FWD ? 'hAA : 5,7,7,ALU_ADD,6,1,0)};
        tbl[2] = '{mk_in(1,3,4,6,5,7,0,ALU_ADD,0,1,0,
                         0,1,'hAA, 3,1,'hBB),
                   1'b0, mk_out(1,FWD ? 'hBB : 5,7,7,ALU_ADD,6,1,0)};
        tbl[3] = '{mk_in(1,0,4,6,'h11,7,0,ALU_ADD,0,1,0,
                         0,1,'hAA, 0,1,'hBB),
                   1'b0, mk_out(1,'h11,7,7,ALU_ADD,6,1,0)};
        tbl[4] = '{mk_in(1,1,2,5,1,2,'h40,ALU_ADD,1,1,1, 0,0,0, 0,0,0),
                   1'b0, mk_out(1,1,'h40,2,ALU_ADD,5,1,1)};
        tbl[5] = '{mk_in(1,7,5,8,9,10,0,ALU_SUB,0,1,0, 0,0,0, 0,0,0),
                   1'b1, mk_out(0,0,0,0,0,0,0,0)};
        tbl[6] = '{mk_in(1,7,5,8,9,10,0,ALU_SUB,0,1,0, 0,0,0, 0,0,0),
                   1'b0, mk_out(1,9,10,10,ALU_SUB,8,1,0)};
        tbl[7] = '{mk_in(1,8,0,9,3,4,0,ALU_AND,0,1,0, 0,0,0, 0,0,0),
                   FWD ? 1'b0 : 1'b1,
                   FWD ? mk_out(1,3,4,4,ALU_AND,9,1,0)
                       : mk_out(0,0,0,0,0,0,0,0)};
        tbl[8] = '{mk_in(0,9,9,10,'h21,'h22,'h33,ALU_OR,1,1,1,
                         0,0,0, 0,0,0),
                   1'b0, mk_out(0,'h21,'h33,'h22,ALU_OR,10,0,0)};
        tbl[9] = '{mk_in(1,2,3,11,5,6,7,ALU_XOR,0,1,0,
                         3,1,'hC0, 2,1,'hD0),
                   1'b0,
                   mk_out(1,FWD ? 'hD0 : 5,FWD ? 'hC0 : 6,
                          FWD ? 'hC0 : 6,ALU_XOR,11,1,0)};

        for (int i = 0; i < 10; i++) begin
            cur = tbl[i].in;
            #1;
            chk_lu($sformatf("tbl%0d_lu", i), tbl[i].lu_pre);
            @(posedge clk);
            #1;
            chk_out($sformatf("tbl%0d_out", i), tbl[i].exp);
        end

        for (int k = 0; k < 3; k++) begin
            cur = tbl[9].in;
            cur.stall = 1'b1;
            cur.valid = 1'($urandom);
            cur.rs1 = RA_W'($urandom);
            cur.rs2 = RA_W'($urandom);
            cur.rd = RA_W'($urandom);
            cur.d1 = $urandom;
            cur.d2 = $urandom;
            cur.imm = $urandom;
            cur.ctrl = 4'($urandom_range(0, 8));
            cur.rw = 1'($urandom);
            cur.mr = 1'($urandom);
            #1;
            @(posedge clk);
            #1;
            chk_out($sformatf("stall%0d", k), tbl[9].exp);
        end

        cur.stall = 1'b1;
        cur.flush = 1'b1;
        @(posedge clk);
        #1;
        chk_out("stall_flush", '0);

        cur = tbl[6].in;
        @(posedge clk);
        #1;
        chk_out("pre_reset_load", tbl[6].exp);
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_reset", '0);
        cur.stall = 1'b1;
        @(posedge clk);
        #1;
        chk_out("reset_hold", '0);
        cur = '0;
        m = '0;
        #1;
        reset = 1'b0;

        for (int n = 0; n < 400; n++) begin
            cur.valid = $urandom_range(0, 3) != 0;
            cur.rs1 = RA_W'($urandom_range(0, 3));
            cur.rs2 = RA_W'($urandom_range(0, 3));
            cur.rd = RA_W'($urandom_range(0, 3));
            cur.d1 = $urandom;
            cur.d2 = $urandom;
            cur.imm = $urandom;
            cur.ctrl = 4'($urandom_range(0, 8));
            cur.src = 1'($urandom);
            cur.rw = 1'($urandom);
            cur.mr = 1'($urandom);
            cur.stall = $urandom_range(0, 7) == 0;
            cur.flush = $urandom_range(0, 9) == 0;
            cur.mrd = RA_W'($urandom_range(0, 3));
            cur.mrw = 1'($urandom);
            cur.mres = $urandom;
            cur.wrd = RA_W'($urandom_range(0, 3));
            cur.wrw = 1'($urandom);
            cur.wres = $urandom;
            #1;
            chk_lu($sformatf("rand%0d_lu", n), m_lu());
            chk_out($sformatf("rand%0d_out", n), m_out());
            @(posedge clk);
            m_step();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
